// File: rtl/preamble_strip.sv
// preamble_strip: hunts for a run of preamble words, drops them, and forwards the
// following fixed-length payload frame with TLAST on its final word.
module preamble_strip #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH = 14,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] preamble_value,
    input  logic [31:0]           preamble_length,
    input  logic [31:0]           frame_length,
    input  logic [DATA_WIDTH-1:0] signal_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] signal_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  last_out,
    output logic                  locked,
    output logic [FCNT_WIDTH-1:0] frame_count,
    output logic                  error
);
    typedef enum logic {HUNT, PAYLOAD} state_t;

    state_t               state;
    logic [1:0]           rst_ff;
    logic                 rst_q;
    logic [CNT_WIDTH-1:0] pcnt, dcnt, flen_q, plen, flen;
    logic                 cfg_bad, accept, match, end_frame;

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge clk or posedge rst)
        if (rst) rst_ff <= 2'b11;
        else rst_ff <= {rst_ff[0], 1'b0};

    assign rst_q     = rst_ff[1];
    assign plen      = preamble_length[CNT_WIDTH-1:0];
    assign flen      = frame_length[CNT_WIDTH-1:0];
    assign cfg_bad   = preamble_length == 0 || frame_length == 0 ||
                       |preamble_length[31:CNT_WIDTH] || |frame_length[31:CNT_WIDTH];
    assign ready_in  = error || state == HUNT || !valid_out || ready_out;
    assign accept    = valid_in && ready_in;
    assign match     = signal_in == preamble_value;
    assign end_frame = dcnt == flen_q - 1'b1;

    always_ff @(posedge clk or posedge rst_q)
        if (rst_q) begin
            state       <= HUNT;
            locked      <= 1'b0;
            pcnt        <= '0;
            dcnt        <= '0;
            flen_q      <= '0;
            signal_out  <= '0;
            valid_out   <= 1'b0;
            last_out    <= 1'b0;
            frame_count <= '0;
            error       <= 1'b0;
        end else begin
            error <= error || cfg_bad;
            if (valid_out && ready_out) begin
                valid_out <= 1'b0;
                last_out  <= 1'b0;
            end
            if (error) begin
                state     <= HUNT;
                locked    <= 1'b0;
                pcnt      <= '0;
                dcnt      <= '0;
                valid_out <= 1'b0;
                last_out  <= 1'b0;
            end else if (accept) begin
                if (state == HUNT) begin
                    if (!match) pcnt <= '0;
                    else if (pcnt == plen - 1'b1) begin
                        state  <= PAYLOAD;
                        locked <= 1'b1;
                        pcnt   <= '0;
                        dcnt   <= '0;
                        flen_q <= flen;
                    end else pcnt <= pcnt + 1'b1;
                end else begin
                    signal_out <= signal_in;
                    valid_out  <= 1'b1;
                    last_out   <= end_frame;
                    if (end_frame) begin
                        state       <= HUNT;
                        locked      <= 1'b0;
                        dcnt        <= '0;
                        frame_count <= frame_count + 1'b1;
                    end else dcnt <= dcnt + 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_preamble_strip.sv
// tb_preamble_strip: builds frames from preamble/payload/noise words and checks the
// stripped output stream, lock, frame count and error against what was sent.
module tb_preamble_strip;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] preamble_value, preamble_length, frame_length, signal_in, signal_out;
    logic        valid_in, ready_in, valid_out, ready_out, last_out, locked, error;
    logic [15:0] frame_count;

    int          compared = 0, mismatched = 0;
    logic [32:0] q[$];
    logic        locked_exp = 1'b0, err_exp = 1'b0;
    int          frames_exp = 0, mode = 0, pat = 0;

    preamble_strip dut (
        .clk(clk), .rst(rst), .preamble_value(preamble_value),
        .preamble_length(preamble_length), .frame_length(frame_length),
        .signal_in(signal_in), .valid_in(valid_in), .ready_in(ready_in),
        .signal_out(signal_out), .valid_out(valid_out), .ready_out(ready_out),
        .last_out(last_out), .locked(locked), .frame_count(frame_count), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, then check what the next rising edge will see.
    task automatic step(input logic v, input logic [31:0] d, output logic acc);
        @(negedge clk);
        ready_out = mode == 0 ? 1'b1 : mode == 1 ? (pat % 4 == 0 || pat % 4 == 3) : 1'($urandom_range(0, 1));
        pat++;
        valid_in  = v;
        signal_in = d;
        #1;
        chk("valid_out", valid_out, q.size() != 0);
        if (q.size() != 0) begin
            chk("signal_out", signal_out, q[0][31:0]);
            chk("last_out", last_out, q[0][32]);
        end
        chk("locked", locked, locked_exp);
        chk("frame_count", frame_count, frames_exp[15:0]);
        chk("error", error, err_exp);
        chk("ready_in", ready_in, (locked_exp && !err_exp) ? !(q.size() != 0 && !ready_out) : 1'b1);
        if (q.size() != 0 && ready_out) q.delete(0);
        acc = v && ready_in;
    endtask

    task automatic send(input logic [31:0] w, input logic pay, input logic lst);
        logic acc;
        int n = 0;
        do begin
            step(1'b1, w, acc);
            n++;
        end while (!acc && n < 64);
        chk("send_accept", acc, 1'b1);
        if (acc && pay && !err_exp) q.push_back({lst, w});
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, acc);
    endtask

    task automatic noise(input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (w == preamble_value) w = ~w;
            send(w, 1'b0, 1'b0);
        end
    endtask

    task automatic frame(input int l, input int f, input logic seq);
        for (int i = 0; i < l; i++) send(preamble_value, 1'b0, 1'b0);
        locked_exp = 1'b1;
        for (int i = 0; i < f; i++) send(seq ? 32'(i) : $urandom, 1'b1, i == f - 1);
        locked_exp = 1'b0;
        frames_exp++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_signal_out"}, signal_out, 32'h0);
        chk({tag, "_valid_out"}, valid_out, 1'b0);
        chk({tag, "_last_out"}, last_out, 1'b0);
        chk({tag, "_locked"}, locked, 1'b0);
        chk({tag, "_frame_count"}, frame_count, 16'h0);
        chk({tag, "_error"}, error, 1'b0);
    endtask

    initial begin
        int l;
        valid_in = 1'b0; signal_in = 32'h0; ready_out = 1'b1;
        preamble_value = 32'hA5A5A5A5; preamble_length = 4; frame_length = 8;
        repeat (2) @(negedge clk);
        #1 check_zero("reset");
        rst = 1'b0;
        idle(4);

        frame(4, 8, 1'b1);
        idle(3);

        for (int i = 0; i < 3; i++) send(preamble_value, 1'b0, 1'b0);
        send(32'h1, 1'b0, 1'b0);
        frame(4, 8, 1'b0);
        idle(2);

        mode = 1; pat = 0;
        noise(2);
        frame(4, 8, 1'b0);
        frame(4, 8, 1'b0);
        mode = 0;
        idle(3);

        mode = 2;
        for (int k = 0; k < 8; k++) begin
            preamble_value  = $urandom;
            preamble_length = $urandom_range(1, 5);
            frame_length    = $urandom_range(1, 6);
            noise($urandom_range(0, 3));
            l = $urandom_range(0, int'(preamble_length) - 1);
            for (int i = 0; i < l; i++) send(preamble_value, 1'b0, 1'b0);
            noise(1);
            frame(int'(preamble_length), int'(frame_length), 1'b0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        mode = 0;
        idle(3);

        preamble_length = 2; frame_length = 1;
        for (int i = 0; i < 3; i++) frame(2, 1, 1'b0);
        idle(3);

        frame_length = 0;
        err_exp = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) send(preamble_value, 1'b0, 1'b0);
        noise(4);
        frame_length = 4;
        idle(2);
        for (int i = 0; i < 4; i++) send(preamble_value, 1'b0, 1'b0);
        noise(4);
        idle(2);

        frame_length = 8; preamble_length = 4;
        @(negedge clk);
        #2 rst = 1'b1;
        valid_in = 1'b0;
        #1 check_zero("err_reset");
        q.delete(); locked_exp = 1'b0; err_exp = 1'b0; frames_exp = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(4);

        for (int i = 0; i < 4; i++) send(preamble_value, 1'b0, 1'b0);
        locked_exp = 1'b1;
        for (int i = 0; i < 3; i++) send($urandom, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        valid_in = 1'b0;
        #1 check_zero("midframe_reset");
        q.delete(); locked_exp = 1'b0; frames_exp = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(4);
        noise(5);
        idle(2);
        frame(4, 8, 1'b0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
